ika87ad_mc_sequencer: RTL and testbench
=======================================

// Module: ika87ad_mc_sequencer
// PURPOSE
//   Micro-program sequencer for the IKA87AD core; it sits between the opcode decoder, the microcode ROM and the bus unit.
//   Takes the start micro-address of each decoded instruction and reads successive microwords from the registered MCROM.
//   Issues one bus cycle per microword (IDLE/RD3/WR3/RD4) and advances on bus completion.
//   An RD4 cycle is the next opcode fetch and ends the instruction.
// PARAMETERS
//   MAX_STEPS   16    microwords allowed per instruction before the watchdog forces an opcode fetch (2..255)
//   STEP_W      8     width of internal step counter; must hold MAX_STEPS
// PORTS
//   i_CLK              in   1   system clock
//   i_RST              in   1   synchronous reset, active-high
//   i_DEC_VALID        in   1   decoder has a start address (pulse or level)
//   i_DEC_ADDR         in   8   start micro-address of decoded instruction
//   o_DEC_ACK          out  1   1-cycle pulse: i_DEC_ADDR accepted
//   o_MCROM_READ_TICK  out  1   ROM read strobe (ROM registers data on this edge)
//   o_MCROM_ADDR       out  8   ROM address (micro-PC)
//   i_MCROM_DATA       in   18  ROM output, valid the cycle after READ_TICK
//   o_MC_WORD          out  18  latched current microword, held until next latch
//   o_MC_VALID         out  1   1-cycle pulse when o_MC_WORD updates
//   o_FLAG_WE          out  1   = MC_WORD[15] qualified by o_MC_VALID
//   i_SKIP_COND        in   1   abort condition, sampled at microword latch
//   o_BUS_REQ          out  1   1-cycle bus cycle request
//   o_BUS_TYPE         out  2   00 IDLE, 01 RD3, 10 WR3, 11 RD4; held while waiting
//   i_BUS_DONE         in   1   1-cycle pulse: requested bus cycle finished
//   o_INST_END         out  1   1-cycle pulse on completion of an RD4 cycle
//   o_SEQ_ERR          out  1   1-cycle pulse when watchdog fires
//   o_BUSY             out  1   high in every state except S_DEC
// BEHAVIOUR
//   Microword fields: [17:16] MCTYPE, [15] FLAG, [14] SKIP, [1:0] bus code; other bits pass through.
//   States: S_ISSUE, S_BUSW, S_DEC, S_RD, S_LAT.
//   Reset: state=S_ISSUE with forced RD4, micro-PC=0, step=0, o_MC_WORD=0; every pulse output is 0.
//   Consequence of reset: the first action after reset is an opcode fetch.
//   Reset during any state abandons the operation at the next edge; o_BUS_REQ drops with no completion pending.
//   S_DEC: wait for i_DEC_VALID. On it: micro-PC<=i_DEC_ADDR, step<=0, o_DEC_ACK=1, then go to S_RD.
//   S_RD: o_MCROM_READ_TICK=1 for exactly one cycle with o_MCROM_ADDR=micro-PC, then go to S_LAT.
//   S_LAT: o_MC_WORD<=i_MCROM_DATA, o_MC_VALID=1, then go to S_ISSUE.
//     If bit14 is set and i_SKIP_COND=1, the microword's bus code is replaced by RD4.
//   S_ISSUE, bus code IDLE: no request. Micro-PC+1 (8-bit wrap FF->00), step+1, then go to S_RD.
//   S_ISSUE, other bus codes: o_BUS_REQ=1 for one cycle, o_BUS_TYPE=code, then go to S_BUSW.
//   S_BUSW: hold o_BUS_TYPE and wait for i_BUS_DONE.
//     Done with RD4: o_INST_END=1, go to S_DEC.
//     Done with RD3/WR3: micro-PC+1, step+1, go to S_RD.
//   Latency: accept to first bus request is 3 cycles (RD, LAT, ISSUE); IDLE microword costs 3 cycles.
//   i_BUS_DONE outside S_BUSW, or in the same cycle as o_BUS_REQ, is ignored.
//   i_DEC_VALID outside S_DEC is ignored and not queued.
//   Watchdog: in S_ISSUE, if step==MAX_STEPS-1 and the code is not RD4, issue RD4 instead and pulse o_SEQ_ERR.
//   o_MCROM_ADDR always shows micro-PC; it is stable while o_MCROM_READ_TICK=0.
// TESTING
//   Reset, then ROM[05]={..,RD3},ROM[06]={..,RD4}; decode 05 -> tick@05, RD3 req, done, tick@06, RD4 req, done, INST_END=1, state S_DEC.
//   IDLE chain: ROM[10..12]=IDLE,IDLE,RD4 -> no BUS_REQ for 10/11; RD4 req exactly 9 cycles after DEC_ACK.
//   ROM[20] bit14=1 code WR3, i_SKIP_COND=1 -> BUS_TYPE=11 (RD4), no WR3 issued; INST_END after done.
//   ROM[FF]=RD3, ROM[00]=RD4, decode FF -> second tick address 00 (wrap).
//   MAX_STEPS=4, ROM[30..3F] all RD3 -> 3 RD3 cycles, 4th request is RD4 with SEQ_ERR=1.
//   Assert i_RST in S_BUSW with BUS_REQ pending -> next cycle S_ISSUE, RD4 req; stray i_BUS_DONE in S_DEC ignored.

Source files
------------

// File: rtl/ika87ad_mc_sequencer_if.sv
// ika87ad_mc_sequencer_if
//   Groups every non-clock/reset signal of the IKA87AD micro-program sequencer:
//   the decoder handshake, the microcode ROM port, the microword outputs and the
//   bus-unit handshake. Signal names keep the i_/o_ prefix as seen from the
//   sequencer, so the same name reads the same on both sides.
// Modports
//   master : the sequencer (drives o_*, samples i_*)
//   slave  : decoder / MCROM / bus unit environment (drives i_*, samples o_*)
interface ika87ad_mc_sequencer_if;
  // Decoder handshake
  logic        i_DEC_VALID;
  logic [7:0]  i_DEC_ADDR;
  logic        o_DEC_ACK;
  // Microcode ROM port
  logic        o_MCROM_READ_TICK;
  logic [7:0]  o_MCROM_ADDR;
  logic [17:0] i_MCROM_DATA;
  // Current microword
  logic [17:0] o_MC_WORD;
  logic        o_MC_VALID;
  logic        o_FLAG_WE;
  logic        i_SKIP_COND;
  // Bus unit handshake
  logic        o_BUS_REQ;
  logic [1:0]  o_BUS_TYPE;
  logic        i_BUS_DONE;
  // Status
  logic        o_INST_END;
  logic        o_SEQ_ERR;
  logic        o_BUSY;

  modport master (
    input  i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA, i_SKIP_COND, i_BUS_DONE,
    output o_DEC_ACK, o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID, o_FLAG_WE,
           o_BUS_REQ, o_BUS_TYPE, o_INST_END, o_SEQ_ERR, o_BUSY
  );

  modport slave (
    output i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA, i_SKIP_COND, i_BUS_DONE,
    input  o_DEC_ACK, o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID, o_FLAG_WE,
           o_BUS_REQ, o_BUS_TYPE, o_INST_END, o_SEQ_ERR, o_BUSY
  );
endinterface

// File: rtl/ika87ad_mc_sequencer.sv
// ika87ad_mc_sequencer
//   Micro-program sequencer for the IKA87AD core. Accepts a start micro-address
//   from the opcode decoder, reads successive microwords from the registered
//   microcode ROM and issues one bus cycle per microword. An RD4 bus cycle is
//   the next opcode fetch and terminates the instruction.
// Parameters
//   MAX_STEPS : microwords allowed per instruction before a forced opcode fetch
//   STEP_W    : width of the step counter, must be able to hold MAX_STEPS
// Ports
//   i_CLK : system clock
//   i_RST : synchronous reset, active high
//   bus   : ika87ad_mc_sequencer_if.master (decoder, MCROM, microword and bus handshakes)
// Microword layout
//   [17:16] MCTYPE, [15] FLAG, [14] SKIP, [1:0] bus code, other bits pass through.
// Cycle behaviour
//   All pulse outputs are registered and are high during the first cycle of the
//   state they belong to (e.g. READ_TICK during the ROM-read state, BUS_REQ
//   during the first bus-wait cycle). Accept-to-first-request is 3 cycles and an
//   IDLE microword costs 3 cycles (read, latch, issue).
module ika87ad_mc_sequencer #(
  parameter int unsigned MAX_STEPS = 16,
  parameter int unsigned STEP_W    = 8
) (
  input logic                   i_CLK,
  input logic                   i_RST,
  ika87ad_mc_sequencer_if.master bus
);

  localparam logic [1:0] BusIdle = 2'b00;
  localparam logic [1:0] BusRd3  = 2'b01;
  localparam logic [1:0] BusWr3  = 2'b10;
  localparam logic [1:0] BusRd4  = 2'b11;

  localparam logic [STEP_W-1:0] StepLast = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [2:0] {
    StIssue,  // decide on the bus cycle for the latched microword
    StBusW,   // wait for the bus unit to finish
    StDec,    // idle, waiting for the decoder
    StRd,     // ROM read strobe
    StLat     // capture ROM output
  } state_e;

  state_e              state_q;
  logic [7:0]          upc_q;       // micro-PC
  logic [STEP_W-1:0]   step_q;      // microwords consumed by this instruction
  logic [1:0]          code_q;      // effective bus code of the current microword
  logic [17:0]         mc_word_q;
  logic                mc_valid_q;
  logic                flag_we_q;
  logic                dec_ack_q;
  logic                tick_q;
  logic                bus_req_q;
  logic [1:0]          bus_type_q;
  logic                inst_end_q;
  logic                seq_err_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      // Reset lands in the issue state with a forced RD4 so the first thing the
      // core does is fetch an opcode.
      state_q    <= StIssue;
      upc_q      <= 8'h00;
      step_q     <= '0;
      code_q     <= BusRd4;
      mc_word_q  <= 18'h0;
      mc_valid_q <= 1'b0;
      flag_we_q  <= 1'b0;
      dec_ack_q  <= 1'b0;
      tick_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_type_q <= BusIdle;
      inst_end_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      dec_ack_q  <= 1'b0;
      tick_q     <= 1'b0;
      mc_valid_q <= 1'b0;
      flag_we_q  <= 1'b0;
      bus_req_q  <= 1'b0;
      inst_end_q <= 1'b0;
      seq_err_q  <= 1'b0;

      unique case (state_q)
        StDec: begin
          if (bus.i_DEC_VALID) begin
            upc_q     <= bus.i_DEC_ADDR;
            step_q    <= '0;
            dec_ack_q <= 1'b1;
            tick_q    <= 1'b1;
            state_q   <= StRd;
          end
        end

        StRd: begin
          // ROM captures its data at the edge ending this cycle.
          state_q <= StLat;
        end

        StLat: begin
          mc_word_q  <= bus.i_MCROM_DATA;
          mc_valid_q <= 1'b1;
          flag_we_q  <= bus.i_MCROM_DATA[15];
          // A SKIP microword aborts the instruction when the condition holds.
          if (bus.i_MCROM_DATA[14] && bus.i_SKIP_COND) begin
            code_q <= BusRd4;
          end else begin
            code_q <= bus.i_MCROM_DATA[1:0];
          end
          state_q <= StIssue;
        end

        StIssue: begin
          if ((step_q == StepLast) && (code_q != BusRd4)) begin
            // Watchdog: too many microwords, force the opcode fetch.
            code_q     <= BusRd4;
            bus_req_q  <= 1'b1;
            bus_type_q <= BusRd4;
            seq_err_q  <= 1'b1;
            state_q    <= StBusW;
          end else if (code_q == BusIdle) begin
            upc_q   <= upc_q + 8'd1;
            step_q  <= step_q + STEP_W'(1);
            tick_q  <= 1'b1;
            state_q <= StRd;
          end else begin
            bus_req_q  <= 1'b1;
            bus_type_q <= code_q;
            state_q    <= StBusW;
          end
        end

        StBusW: begin
          // A done coinciding with our own request cannot belong to it.
          if (bus.i_BUS_DONE && !bus_req_q) begin
            if (code_q == BusRd4) begin
              inst_end_q <= 1'b1;
              state_q    <= StDec;
            end else begin
              upc_q   <= upc_q + 8'd1;
              step_q  <= step_q + STEP_W'(1);
              tick_q  <= 1'b1;
              state_q <= StRd;
            end
          end
        end

        default: begin
          state_q <= StIssue;
        end
      endcase
    end
  end

  assign bus.o_DEC_ACK         = dec_ack_q;
  assign bus.o_MCROM_READ_TICK = tick_q;
  assign bus.o_MCROM_ADDR      = upc_q;
  assign bus.o_MC_WORD         = mc_word_q;
  assign bus.o_MC_VALID        = mc_valid_q;
  assign bus.o_FLAG_WE         = flag_we_q;
  assign bus.o_BUS_REQ         = bus_req_q;
  assign bus.o_BUS_TYPE        = bus_type_q;
  assign bus.o_INST_END        = inst_end_q;
  assign bus.o_SEQ_ERR         = seq_err_q;
  assign bus.o_BUSY            = (state_q != StDec);

  // Only the RD3/WR3 encodings are otherwise unreferenced by name.
  logic unused_codes;
  assign unused_codes = ^{BusRd3, BusWr3};

endmodule

// File: tb/tb_ika87ad_mc_sequencer.sv
// Bench for ika87ad_mc_sequencer (MAX_STEPS=4). A behavioural registered ROM and
// a bus unit answer the DUT; expected ROM addresses, microwords and bus requests
// are queued when an instruction is launched and popped as the DUT produces them.
module tb_ika87ad_mc_sequencer;

  localparam logic [1:0] RD3 = 2'b01;
  localparam logic [1:0] WR3 = 2'b10;
  localparam logic [1:0] RD4 = 2'b11;
  localparam logic [1:0] IDL = 2'b00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ika87ad_mc_sequencer_if bus_if ();

  ika87ad_mc_sequencer #(
    .MAX_STEPS(4),
    .STEP_W   (8)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus_if)
  );

  // Registered microcode ROM.
  logic [17:0] rom [256];
  logic [17:0] rom_dout = 18'h0;
  always @(posedge clk) begin
    if (bus_if.o_MCROM_READ_TICK) rom_dout <= rom[bus_if.o_MCROM_ADDR];
  end
  assign bus_if.i_MCROM_DATA = rom_dout;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tick_exp [$];
  logic [17:0] word_exp [$];
  logic [2:0]  req_exp  [$];  // {seq_err, bus_type}

  typedef struct {
    logic [7:0]  start;
    logic        skip;
    int          nw;    // microwords read
    int          nreq;  // bus requests issued
    logic [11:0] reqs;  // entry i at [3*i +: 3]
    int          lat;   // DEC_ACK to first BUS_REQ, in cycles
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [17:0] mw(input logic [7:0] a, input logic f, input logic s,
                                     input logic [1:0] c);
    return {a[1:0], f, s, 4'h0, a, c};
  endfunction

  function automatic logic [11:0] pk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] c, input logic [2:0] d);
    return {d, c, b, a};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int   ack_cyc  = 0;
    int   n_ack    = 0;
    int   n_end    = 0;
    int   done_in  = -1;
    bit   seen_req = 1'b0;
    bit   fin      = 1'b0;
    logic [7:0]  ea;
    logic [17:0] ew;
    logic [2:0]  er;
    for (int i = 0; i < v.nw; i++) begin
      ea = v.start + 8'(i);
      tick_exp.push_back(ea);
      word_exp.push_back(rom[ea]);
    end
    for (int i = 0; i < v.nreq; i++) req_exp.push_back(v.reqs[3*i +: 3]);
    bus_if.i_SKIP_COND = v.skip;
    bus_if.i_DEC_ADDR  = v.start;
    bus_if.i_DEC_VALID = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      bus_if.i_BUS_DONE = 1'b0;
      if (done_in == 0) begin
        bus_if.i_BUS_DONE = 1'b1;
        done_in = -1;
      end else if (done_in > 0) begin
        done_in--;
      end
      if (bus_if.o_DEC_ACK) begin
        n_ack++;
        ack_cyc = cyc;
        chk($sformatf("v%0d_busy_at_ack", idx), 32'(bus_if.o_BUSY), 32'd1);
        // Keep a different request up while busy; it must not be taken.
        bus_if.i_DEC_ADDR = 8'hEE;
      end
      if (bus_if.o_MCROM_READ_TICK) begin
        if (tick_exp.size() == 0) fail_now($sformatf("v%0d_unexpected_tick", idx));
        else begin
          ea = tick_exp.pop_front();
          chk($sformatf("v%0d_tick_addr", idx), 32'(bus_if.o_MCROM_ADDR), 32'(ea));
        end
      end
      if (bus_if.o_MC_VALID) begin
        if (word_exp.size() == 0) fail_now($sformatf("v%0d_unexpected_word", idx));
        else begin
          ew = word_exp.pop_front();
          chk($sformatf("v%0d_mc_word", idx), 32'(bus_if.o_MC_WORD), 32'(ew));
          chk($sformatf("v%0d_flag_we", idx), 32'(bus_if.o_FLAG_WE), 32'(ew[15]));
        end
      end
      if (bus_if.o_BUS_REQ) begin
        if (req_exp.size() == 0) fail_now($sformatf("v%0d_unexpected_req", idx));
        else begin
          er = req_exp.pop_front();
          chk($sformatf("v%0d_bus_type", idx), 32'(bus_if.o_BUS_TYPE), 32'(er[1:0]));
          chk($sformatf("v%0d_seq_err", idx), 32'(bus_if.o_SEQ_ERR), 32'(er[2]));
        end
        if (!seen_req) chk($sformatf("v%0d_latency", idx), 32'(cyc - ack_cyc), 32'(v.lat));
        seen_req = 1'b1;
        done_in  = 1;
      end
      if (bus_if.o_INST_END) begin
        n_end++;
        fin = 1'b1;
        bus_if.i_DEC_VALID = 1'b0;
        chk($sformatf("v%0d_idle_after_end", idx), 32'(bus_if.o_BUSY), 32'd0);
      end
    end
    bus_if.i_DEC_VALID = 1'b0;
    bus_if.i_BUS_DONE  = 1'b0;
    chk($sformatf("v%0d_ack_count", idx), 32'(n_ack), 32'd1);
    chk($sformatf("v%0d_inst_end", idx), 32'(n_end), 32'd1);
    chk($sformatf("v%0d_leftover", idx),
        32'(tick_exp.size() + word_exp.size() + req_exp.size()), 32'd0);
    tick_exp.delete();
    word_exp.delete();
    req_exp.delete();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = mw(8'(a), 1'b0, 1'b0, RD4);
    rom[8'h05] = mw(8'h05, 1'b0, 1'b0, RD3);
    rom[8'h06] = mw(8'h06, 1'b1, 1'b0, RD4);
    rom[8'h10] = mw(8'h10, 1'b0, 1'b0, IDL);
    rom[8'h11] = mw(8'h11, 1'b0, 1'b0, IDL);
    rom[8'h12] = mw(8'h12, 1'b0, 1'b0, RD4);
    rom[8'h20] = mw(8'h20, 1'b1, 1'b1, WR3);
    rom[8'h21] = mw(8'h21, 1'b0, 1'b0, RD4);
    rom[8'hFF] = mw(8'hFF, 1'b0, 1'b0, RD3);
    rom[8'h00] = mw(8'h00, 1'b0, 1'b0, RD4);
    for (int a = 8'h30; a <= 8'h3F; a++) rom[a] = mw(8'(a), 1'b0, 1'b0, RD3);
    rom[8'h40] = mw(8'h40, 1'b0, 1'b1, RD3);
    rom[8'h41] = mw(8'h41, 1'b0, 1'b0, RD4);
    rom[8'h50] = mw(8'h50, 1'b0, 1'b0, IDL);
    rom[8'h51] = mw(8'h51, 1'b1, 1'b0, WR3);
    rom[8'h52] = mw(8'h52, 1'b0, 1'b0, RD4);
    for (int a = 8'h60; a <= 8'h63; a++) rom[a] = mw(8'(a), 1'b0, 1'b0, IDL);

    vecs[0] = '{8'h05, 1'b0, 2, 2, pk({1'b0, RD3}, {1'b0, RD4}, 3'b0, 3'b0), 3};
    vecs[1] = '{8'h10, 1'b0, 3, 1, pk({1'b0, RD4}, 3'b0, 3'b0, 3'b0), 9};
    vecs[2] = '{8'h20, 1'b1, 1, 1, pk({1'b0, RD4}, 3'b0, 3'b0, 3'b0), 3};
    vecs[3] = '{8'h20, 1'b0, 2, 2, pk({1'b0, WR3}, {1'b0, RD4}, 3'b0, 3'b0), 3};
    vecs[4] = '{8'hFF, 1'b0, 2, 2, pk({1'b0, RD3}, {1'b0, RD4}, 3'b0, 3'b0), 3};
    vecs[5] = '{8'h30, 1'b0, 4, 4, pk({1'b0, RD3}, {1'b0, RD3}, {1'b0, RD3}, {1'b1, RD4}), 3};
    vecs[6] = '{8'h05, 1'b1, 2, 2, pk({1'b0, RD3}, {1'b0, RD4}, 3'b0, 3'b0), 3};
    vecs[7] = '{8'h40, 1'b0, 2, 2, pk({1'b0, RD3}, {1'b0, RD4}, 3'b0, 3'b0), 3};
    vecs[8] = '{8'h50, 1'b0, 3, 2, pk({1'b0, WR3}, {1'b0, RD4}, 3'b0, 3'b0), 6};
    vecs[9] = '{8'h60, 1'b0, 4, 1, pk({1'b1, RD4}, 3'b0, 3'b0, 3'b0), 12};

    bus_if.i_DEC_VALID = 1'b0;
    bus_if.i_DEC_ADDR  = 8'h00;
    bus_if.i_SKIP_COND = 1'b0;
    bus_if.i_BUS_DONE  = 1'b0;

    // Reset state, then the forced opcode fetch.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus_if.o_BUSY), 32'd1);
    chk("rst_mc_word", 32'(bus_if.o_MC_WORD), 32'd0);
    chk("rst_upc", 32'(bus_if.o_MCROM_ADDR), 32'd0);
    chk("rst_pulses", 32'({bus_if.o_BUS_REQ, bus_if.o_DEC_ACK, bus_if.o_MC_VALID,
        bus_if.o_INST_END, bus_if.o_SEQ_ERR, bus_if.o_MCROM_READ_TICK, bus_if.o_FLAG_WE}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("boot_req", 32'(bus_if.o_BUS_REQ), 32'd1);
    chk("boot_type", 32'(bus_if.o_BUS_TYPE), 32'(RD4));
    chk("boot_seq_err", 32'(bus_if.o_SEQ_ERR), 32'd0);
    bus_if.i_BUS_DONE = 1'b1;  // coincides with BUS_REQ: ignored
    @(negedge clk);
    bus_if.i_BUS_DONE = 1'b0;
    chk("same_cycle_done_ignored", 32'(bus_if.o_INST_END), 32'd0);
    chk("boot_type_held", 32'(bus_if.o_BUS_TYPE), 32'(RD4));
    @(negedge clk);
    chk("boot_still_waiting", 32'(bus_if.o_BUSY), 32'd1);
    bus_if.i_BUS_DONE = 1'b1;
    @(negedge clk);
    bus_if.i_BUS_DONE = 1'b0;
    chk("boot_inst_end", 32'(bus_if.o_INST_END), 32'd1);
    chk("boot_idle", 32'(bus_if.o_BUSY), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while waiting on a bus cycle.
    bus_if.i_SKIP_COND = 1'b0;
    bus_if.i_DEC_ADDR  = 8'h05;
    bus_if.i_DEC_VALID = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_if.o_DEC_ACK) bus_if.i_DEC_VALID = 1'b0;
      if (bus_if.o_BUS_REQ) break;
    end
    bus_if.i_DEC_VALID = 1'b0;
    chk("mid_req_seen", 32'(bus_if.o_BUS_REQ), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req_drop", 32'(bus_if.o_BUS_REQ), 32'd0);
    chk("mid_rst_busy", 32'(bus_if.o_BUSY), 32'd1);
    chk("mid_rst_upc", 32'(bus_if.o_MCROM_ADDR), 32'd0);
    chk("mid_rst_word", 32'(bus_if.o_MC_WORD), 32'd0);
    @(negedge clk);
    chk("mid_rst_fetch_req", 32'(bus_if.o_BUS_REQ), 32'd1);
    chk("mid_rst_fetch_type", 32'(bus_if.o_BUS_TYPE), 32'(RD4));
    @(negedge clk);
    bus_if.i_BUS_DONE = 1'b1;
    @(negedge clk);
    bus_if.i_BUS_DONE = 1'b0;
    chk("mid_rst_inst_end", 32'(bus_if.o_INST_END), 32'd1);

    // Stray completion while idle.
    bus_if.i_BUS_DONE = 1'b1;
    @(negedge clk);
    bus_if.i_BUS_DONE = 1'b0;
    chk("stray_done_idle", 32'(bus_if.o_BUSY), 32'd0);
    chk("stray_done_no_end", 32'(bus_if.o_INST_END), 32'd0);
    chk("stray_done_no_tick", 32'({bus_if.o_BUS_REQ, bus_if.o_MCROM_READ_TICK}), 32'd0);

    run_vec(10, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
